// File: rtl/vec_normalize.sv
// vec_normalize: buffers one vector of VEC_LEN complex floating-point samples,
// waits for its 1/||v|| scale word (from inv_sqrt), then streams every element
// multiplied by that scale through two fp_mul pipelines (real / imaginary).
// The next vector is accepted only once the current one has fully drained.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   element handshake; in_re/in_im element components
//   scale_valid, scale  one-cycle scale pulse and scale word
//   odata_re/odata_im   scaled components (held while out_valid=0)
//   out_valid, out_last output strobe and last-element marker
//   busy                vector in flight or scale held
//   scale_err           sticky: surplus scale pulse was dropped

// fp_mul: IEEE-style multiply, round-to-nearest-even, subnormals flushed to
// zero, overflow and Inf/NaN inputs saturate to signed infinity.
// MUL_LAT register stages, all advancing only while enable is high.
module fp_mul #(
    parameter int I_EXP   = 8,
    parameter int I_MNT   = 23,
    parameter int I_DATA  = I_EXP + I_MNT + 1,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              enable,
    input  logic [I_DATA-1:0] idataA,
    input  logic [I_DATA-1:0] idataB,
    output logic [I_DATA-1:0] odata
);
    localparam int BIAS = (1 << (I_EXP - 1)) - 1;
    localparam int EMAX = (1 << I_EXP) - 1;

    function automatic logic [I_DATA-1:0] fmul(input logic [I_DATA-1:0] a,
                                               input logic [I_DATA-1:0] b);
        logic               sgn;
        logic [I_EXP-1:0]   ea, eb;
        logic [2*I_MNT+1:0] p;
        logic [I_MNT-1:0]   m;
        logic [I_MNT:0]     mr;
        logic               g, st;
        int                 e;
        sgn = a[I_DATA-1] ^ b[I_DATA-1];
        ea  = a[I_DATA-2:I_MNT];
        eb  = b[I_DATA-2:I_MNT];
        p   = {{(I_MNT+1){1'b0}}, 1'b1, a[I_MNT-1:0]} *
              {{(I_MNT+1){1'b0}}, 1'b1, b[I_MNT-1:0]};
        e   = int'(ea) + int'(eb) - BIAS;
        // Product of two [1,2) mantissas lies in [1,4): renormalise on the top bit.
        if (p[2*I_MNT+1]) begin
            m  = p[2*I_MNT:I_MNT+1];
            g  = p[I_MNT];
            st = |p[I_MNT-1:0];
            e  = e + 1;
        end else begin
            m  = p[2*I_MNT-1:I_MNT];
            g  = p[I_MNT-1];
            st = |p[I_MNT-2:0];
        end
        mr = {1'b0, m} + {{I_MNT{1'b0}}, (g & (st | m[0]))};
        if (mr[I_MNT]) e = e + 1;  // rounding carried out; mantissa is already 0
        if (ea == '0 || eb == '0)
            return {sgn, {(I_DATA-1){1'b0}}};
        else if (ea == '1 || eb == '1 || e >= EMAX)
            return {sgn, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
        else if (e <= 0)
            return {sgn, {(I_DATA-1){1'b0}}};
        else
            return {sgn, e[I_EXP-1:0], mr[I_MNT-1:0]};
    endfunction

    logic [I_DATA-1:0] pipe_q [MUL_LAT];

    always_ff @(posedge clk) begin
        if (enable) begin
            pipe_q[0] <= fmul(idataA, idataB);
            for (int unsigned i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign odata = pipe_q[MUL_LAT-1];
endmodule

module vec_normalize #(
    parameter int I_EXP   = 8,
    parameter int I_MNT   = 23,
    parameter int I_DATA  = I_EXP + I_MNT + 1,
    parameter int VEC_LEN = 4,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [I_DATA-1:0] in_re,
    input  logic [I_DATA-1:0] in_im,
    output logic              in_ready,
    input  logic              scale_valid,
    input  logic [I_DATA-1:0] scale,
    output logic [I_DATA-1:0] odata_re,
    output logic [I_DATA-1:0] odata_im,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              scale_err
);
    localparam int CW = $clog2(VEC_LEN);
    localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);
    localparam logic [DW-1:0] DRN_LAST = DW'(MUL_LAT - 1);

    typedef enum logic [1:0] {FILL, WAIT_SCALE, SCALE, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [DW-1:0]     drn_cnt_q, drn_cnt_d;
    logic [I_DATA-1:0] scale_q, scale_d;
    logic              scale_held_q, scale_held_d;
    logic              scale_err_q, scale_err_d;
    logic [I_DATA-1:0] buf_re_q [VEC_LEN];
    logic [I_DATA-1:0] buf_im_q [VEC_LEN];
    logic [MUL_LAT-1:0] vld_q, last_q;
    logic [I_DATA-1:0] hold_re_q, hold_im_q;
    logic [I_DATA-1:0] mul_re, mul_im;
    logic              accept, scale_ok, issue, mul_en;

    assign in_ready = (state_q == FILL);
    assign accept   = in_valid & in_ready;
    assign issue    = (state_q == SCALE);
    assign mul_en   = (state_q == SCALE) || (state_q == DRAIN);
    // A scale is only taken while none is held and no vector is being scaled.
    assign scale_ok = scale_valid && !scale_held_q &&
                      (state_q == FILL || state_q == WAIT_SCALE);

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        drn_cnt_d    = drn_cnt_q;
        scale_d      = scale_q;
        scale_held_d = scale_held_q;
        scale_err_d  = scale_err_q;

        if (scale_ok) begin
            scale_d      = scale;
            scale_held_d = 1'b1;
        end else if (scale_valid) begin
            scale_err_d = 1'b1;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = (scale_held_q || scale_valid) ? SCALE : WAIT_SCALE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_SCALE: begin
                if (scale_valid) state_d = SCALE;
            end
            SCALE: begin
                if (rd_cnt_q == LAST_IDX) begin
                    rd_cnt_d = '0;
                    state_d  = DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drn_cnt_q == DRN_LAST) begin
                    drn_cnt_d    = '0;
                    scale_held_d = 1'b0;
                    state_d      = FILL;
                end else begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            drn_cnt_q    <= '0;
            scale_q      <= '0;
            scale_held_q <= 1'b0;
            scale_err_q  <= 1'b0;
            vld_q        <= '0;
            last_q       <= '0;
            hold_re_q    <= '0;
            hold_im_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            drn_cnt_q    <= drn_cnt_d;
            scale_q      <= scale_d;
            scale_held_q <= scale_held_d;
            scale_err_q  <= scale_err_d;
            // Valid/last tags travel alongside the multiplier pipeline; clearing
            // them on reset kills any element still inside fp_mul.
            vld_q[0]     <= issue;
            last_q[0]    <= issue && (rd_cnt_q == LAST_IDX);
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
            if (vld_q[MUL_LAT-1]) begin
                hold_re_q <= mul_re;
                hold_im_q <= mul_im;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_re_q[wr_cnt_q] <= in_re;
            buf_im_q[wr_cnt_q] <= in_im;
        end
    end

    fp_mul #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA), .MUL_LAT(MUL_LAT)) u_mul_re (
        .clk    (clk),
        .enable (mul_en),
        .idataA (buf_re_q[rd_cnt_q]),
        .idataB (scale_q),
        .odata  (mul_re)
    );

    fp_mul #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA), .MUL_LAT(MUL_LAT)) u_mul_im (
        .clk    (clk),
        .enable (mul_en),
        .idataA (buf_im_q[rd_cnt_q]),
        .idataB (scale_q),
        .odata  (mul_im)
    );

    // The multiplier keeps shifting during DRAIN, so outputs are muxed with the
    // last valid result to hold steady between vectors.
    assign out_valid = vld_q[MUL_LAT-1];
    assign out_last  = last_q[MUL_LAT-1];
    assign odata_re  = out_valid ? mul_re : hold_re_q;
    assign odata_im  = out_valid ? mul_im : hold_im_q;
    assign busy      = (state_q != FILL) || scale_held_q;
    assign scale_err = scale_err_q;
endmodule

// File: tb/tb_vec_normalize.sv
// Directed self-checking bench for vec_normalize (VEC_LEN=4, MUL_LAT=3, fp32).
module tb_vec_normalize;
    localparam int W  = 32;
    localparam int VL = 4;
    localparam int ML = 3;

    logic         clk = 1'b0;
    logic         reset, in_valid, scale_valid;
    logic [W-1:0] in_re, in_im, scale;
    logic [W-1:0] odata_re, odata_im;
    logic         in_ready, out_valid, out_last, busy, scale_err;

    vec_normalize #(.I_EXP(8), .I_MNT(23), .VEC_LEN(VL), .MUL_LAT(ML)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_ready    (in_ready),
        .scale_valid (scale_valid),
        .scale       (scale),
        .odata_re    (odata_re),
        .odata_im    (odata_im),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .busy        (busy),
        .scale_err   (scale_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
    } obs_t;
    obs_t q[$];

    always @(negedge clk) begin
        if (out_valid) begin
            obs_t o;
            o.c    = cyc;
            o.re   = odata_re;
            o.im   = odata_im;
            o.last = out_last;
            q.push_back(o);
        end
    end

    typedef struct {
        logic [W-1:0] re  [VL];
        logic [W-1:0] im  [VL];
        logic [W-1:0] sc;
        int           spos;  // <0: before first element, 0: with last, >0: cycles after last
        logic [W-1:0] ere [VL];
        logic [W-1:0] eim [VL];
    } vec_t;
    vec_t tbl [3];

    logic [W-1:0] exp_re [VL];
    logic [W-1:0] exp_im [VL];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag, input int n);
        for (int i = 0; i < 80 && q.size() < n; i++) step();
        chk({tag, "_count"}, 64'(q.size()), 64'(n));
    endtask

    // Checks VL outputs starting at q[base], element k due in cycle s+k+ML.
    task automatic check_vec(input string tag, input int s, input int base);
        wait_out(tag, base + VL);
        for (int k = 0; k < VL; k++) begin
            if (q.size() > base + k) begin
                chk($sformatf("%s_t%0d", tag, k), 64'(q[base+k].c), 64'(s + k + ML));
                chk($sformatf("%s_re%0d", tag, k), 64'(q[base+k].re), 64'(exp_re[k]));
                chk($sformatf("%s_im%0d", tag, k), 64'(q[base+k].im), 64'(exp_im[k]));
                chk($sformatf("%s_last%0d", tag, k), 64'(q[base+k].last), 64'(k == VL - 1));
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && busy; i++) step();
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic pulse_scale(input logic [W-1:0] v);
        scale_valid = 1'b1;
        scale       = v;
        step();
        scale_valid = 1'b0;
    endtask

    task automatic run_vector(input int v);
        int a, c, s;
        string tag;
        tag = $sformatf("vec%0d", v);
        q.delete();
        a = 0;
        c = 0;
        if (tbl[v].spos < 0) begin
            c = cyc;
            pulse_scale(tbl[v].sc);
            step();
        end
        for (int k = 0; k < VL; k++) begin
            chk($sformatf("%s_ready%0d", tag, k), 64'(in_ready), 64'(1));
            in_valid = 1'b1;
            in_re    = tbl[v].re[k];
            in_im    = tbl[v].im[k];
            if (k == VL - 1) begin
                a = cyc;
                if (tbl[v].spos == 0) begin
                    scale_valid = 1'b1;
                    scale       = tbl[v].sc;
                    c           = cyc;
                end
            end
            step();
            scale_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk({tag, "_ready_after_fill"}, 64'(in_ready), 64'(0));
        if (tbl[v].spos > 0) begin
            repeat (tbl[v].spos - 1) step();
            c = cyc;
            pulse_scale(tbl[v].sc);
        end
        s = ((a > c) ? a : c) + 1;
        for (int k = 0; k < VL; k++) begin
            exp_re[k] = tbl[v].ere[k];
            exp_im[k] = tbl[v].eim[k];
        end
        check_vec(tag, s, 0);
        wait_idle(tag);
        chk({tag, "_hold_im"}, 64'(odata_im), 64'(exp_im[VL-1]));
        chk({tag, "_hold_re"}, 64'(odata_re), 64'(exp_re[VL-1]));
    endtask

    logic [W-1:0] stim [12];
    int a1, a2, c2;

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        scale_valid = 1'b0;
        in_re       = '0;
        in_im       = '0;
        scale       = '0;

        // {2,4,-1,0} + j1, scale 0.5 five cycles after the last element
        tbl[0].re   = '{32'h40000000, 32'h40800000, 32'hBF800000, 32'h00000000};
        tbl[0].im   = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        tbl[0].sc   = 32'h3F000000;
        tbl[0].spos = 5;
        tbl[0].ere  = '{32'h3F800000, 32'h40000000, 32'hBF000000, 32'h00000000};
        tbl[0].eim  = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
        // same vector, scale 0.25 latched before the first element
        tbl[1].re   = tbl[0].re;
        tbl[1].im   = tbl[0].im;
        tbl[1].sc   = 32'h3E800000;
        tbl[1].spos = -1;
        tbl[1].ere  = '{32'h3F000000, 32'h3F800000, 32'hBE800000, 32'h00000000};
        tbl[1].eim  = '{32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000};
        // scale 0.5 in the same cycle as the last accept
        tbl[2]      = tbl[0];
        tbl[2].spos = 0;

        repeat (3) step();
        reset = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_scale_err", 64'(scale_err), 64'(0));
        chk("rst_odata_re", 64'(odata_re), 64'(0));
        chk("rst_odata_im", 64'(odata_im), 64'(0));

        for (int v = 0; v < 3; v++) run_vector(v);
        chk("no_err_yet", 64'(scale_err), 64'(0));

        // Two scales during FILL: first one wins, error is sticky.
        q.delete();
        a1 = 0;
        for (int k = 0; k < VL; k++) begin
            in_valid = 1'b1;
            in_re    = tbl[0].re[k];
            in_im    = tbl[0].im[k];
            if (k == 0) begin scale_valid = 1'b1; scale = 32'h3F000000; end
            if (k == 1) begin scale_valid = 1'b1; scale = 32'h40000000; end
            if (k == VL - 1) a1 = cyc;
            step();
            scale_valid = 1'b0;
            if (k == 0) chk("dbl_err_after_first", 64'(scale_err), 64'(0));
            if (k == 1) chk("dbl_err_after_second", 64'(scale_err), 64'(1));
        end
        in_valid = 1'b0;
        for (int k = 0; k < VL; k++) begin
            exp_re[k] = tbl[0].ere[k];
            exp_im[k] = tbl[0].eim[k];
        end
        check_vec("dbl", a1 + 1, 0);
        wait_idle("dbl");
        chk("dbl_err_sticky", 64'(scale_err), 64'(1));

        // in_valid held high for 12 cycles; scale 0.5 with the first element.
        stim = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000,
                 32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h40400000};
        q.delete();
        a1 = 0;
        for (int j = 0; j < 12; j++) begin
            chk($sformatf("cont_ready%0d", j), 64'(in_ready), 64'(j < 4 || j == 11));
            in_valid = 1'b1;
            in_re    = stim[j];
            in_im    = 32'h3F800000;
            if (j == 0) begin scale_valid = 1'b1; scale = 32'h3F000000; end
            if (j == 3) a1 = cyc;
            step();
            scale_valid = 1'b0;
        end
        // remaining three elements of the second vector
        a2 = 0;
        for (int k = 0; k < 3; k++) begin
            in_re = (k == 0) ? 32'h40A00000 : (k == 1) ? 32'h40C00000 : 32'h40E00000;
            if (k == 2) a2 = cyc;
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        chk("cont_count_before_scale2", 64'(q.size()), 64'(4));
        chk("cont_wait_busy", 64'(busy), 64'(1));
        exp_re = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000};
        exp_im = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
        check_vec("cont1", a1 + 1, 0);
        c2 = cyc;
        pulse_scale(32'h3E800000);
        exp_re = '{32'h3F400000, 32'h3FA00000, 32'h3FC00000, 32'h3FE00000};
        exp_im = '{32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000};
        check_vec("cont2", ((a2 > c2) ? a2 : c2) + 1, 4);
        wait_idle("cont2");
        chk("cont_total", 64'(q.size()), 64'(8));

        // Reset one cycle into SCALE.
        q.delete();
        pulse_scale(32'h3F000000);
        step();
        for (int k = 0; k < VL; k++) begin
            in_valid = 1'b1;
            in_re    = tbl[0].re[k];
            in_im    = tbl[0].im[k];
            step();
        end
        in_valid = 1'b0;
        chk("rmid_in_scale", 64'(busy), 64'(1));
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_ready", 64'(in_ready), 64'(1));
        chk("rmid_busy", 64'(busy), 64'(0));
        chk("rmid_err", 64'(scale_err), 64'(0));
        chk("rmid_valid", 64'(out_valid), 64'(0));
        chk("rmid_odata_re", 64'(odata_re), 64'(0));
        repeat (ML + VL) step();
        chk("rmid_no_outputs", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
